// File: rtl/seq_shift_add_mult8.sv
// Sequential 8x8 unsigned shift-and-add multiplier with a free-running control loop.
// Each pass loads the operands, runs 8 verify/add/shift iterations, then pulses d_end.
module seq_shift_add_mult8 (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  b,
   input  logic [7:0]  q,
   output logic [15:0] result,
   output logic        d_end
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_VERIFY = 3'd1,
      S_ADD    = 3'd2,
      S_SHIFT  = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   // Shift-register control codes: hold, shift right, shift left, parallel load.
   localparam logic [1:0] SR_HOLD  = 2'b00;
   localparam logic [1:0] SR_RIGHT = 2'b01;
   localparam logic [1:0] SR_LEFT  = 2'b10;
   localparam logic [1:0] SR_LOAD  = 2'b11;

   state_t      state_q, state_d;
   logic [8:0]  a_q, a_d;
   logic [7:0]  b_q, b_d;
   logic [7:0]  qr_q, qr_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        d_end_q;

   logic [1:0]  a_ctl, b_ctl, qr_ctl;
   logic [8:0]  a_par;
   logic        cnt_ld, cnt_en;
   logic        c_end;
   logic [8:0]  sum;

   function automatic logic [8:0] shreg9(input logic [1:0] ctl, input logic [8:0] cur,
                                         input logic sin, input logic [8:0] par);
      logic [8:0] r;
      case (ctl)
         SR_RIGHT: r = {sin, cur[8:1]};
         SR_LEFT:  r = {cur[7:0], 1'b0};
         SR_LOAD:  r = par;
         default:  r = cur;
      endcase
      return r;
   endfunction

   function automatic logic [7:0] shreg8(input logic [1:0] ctl, input logic [7:0] cur,
                                         input logic sin, input logic [7:0] par);
      logic [7:0] r;
      case (ctl)
         SR_RIGHT: r = {sin, cur[7:1]};
         SR_LEFT:  r = {cur[6:0], 1'b0};
         SR_LOAD:  r = par;
         default:  r = cur;
      endcase
      return r;
   endfunction

   // A[8] is deliberately excluded from the adder; it only captures the carry.
   assign sum   = {1'b0, a_q[7:0]} + {1'b0, b_q};
   assign c_end = (cnt_q == 4'd0);

   always_comb begin
      a_ctl   = SR_HOLD;
      b_ctl   = SR_HOLD;
      qr_ctl  = SR_HOLD;
      a_par   = 9'd0;
      cnt_ld  = 1'b0;
      cnt_en  = 1'b0;
      state_d = S_IDLE;
      case (state_q)
         S_IDLE: begin
            a_ctl   = SR_LOAD;
            b_ctl   = SR_LOAD;
            qr_ctl  = SR_LOAD;
            cnt_ld  = 1'b1;
            state_d = S_VERIFY;
         end
         S_VERIFY: state_d = qr_q[0] ? S_ADD : S_SHIFT;
         S_ADD: begin
            a_ctl   = SR_LOAD;
            a_par   = sum;
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            a_ctl   = SR_RIGHT;
            qr_ctl  = SR_RIGHT;
            cnt_en  = 1'b1;
            state_d = c_end ? S_DONE : S_VERIFY;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      a_d  = shreg9(a_ctl, a_q, 1'b0, a_par);
      b_d  = shreg8(b_ctl, b_q, 1'b0, b);
      qr_d = shreg8(qr_ctl, qr_q, a_q[0], q);
      cnt_d = cnt_q;
      if (cnt_ld)
         cnt_d = 4'd7;
      else if (cnt_en)
         cnt_d = cnt_q - 4'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         a_q     <= 9'd0;
         b_q     <= 8'd0;
         qr_q    <= 8'd0;
         cnt_q   <= 4'd0;
         d_end_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         qr_q    <= qr_d;
         cnt_q   <= cnt_d;
         d_end_q <= (state_d == S_DONE);
      end
   end

   assign result = {a_q[7:0], qr_q};
   assign d_end  = d_end_q;

endmodule

// File: tb/tb_seq_shift_add_mult8.sv
// Scoreboard bench: stimulus pushes expected product and pulse cycle, a monitor checks each d_end pulse.
module tb_seq_shift_add_mult8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  b = 8'd0;
   logic [7:0]  q = 8'd0;
   logic [15:0] result;
   logic        d_end;

   seq_shift_add_mult8 dut (
      .clk    (clk),
      .rst    (rst),
      .b      (b),
      .q      (q),
      .result (result),
      .d_end  (d_end)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] prod;
      int          done_cyc;
      logic [7:0]  b;
      logic [7:0]  q;
   } exp_t;

   exp_t sb_q[$];
   int   cyc;
   int   idle_cyc;
   int   n_checks = 0;
   int   n_fail   = 0;

   // Cycle index since reset release; cycle 0 is the first IDLE cycle.
   always @(posedge clk or negedge rst) begin
      if (!rst) cyc <= 0;
      else      cyc <= cyc + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: product is plain multiplication; pulse lands 17+popcount(q) cycles after IDLE.
   task automatic run_op(input logic [7:0] bb, input logic [7:0] qq, input bit junk);
      exp_t e;
      while (cyc < idle_cyc) @(negedge clk);
      b = bb;
      q = qq;
      e.prod     = {8'd0, bb} * {8'd0, qq};
      e.done_cyc = idle_cyc + 17 + $countones(qq);
      e.b        = bb;
      e.q        = qq;
      sb_q.push_back(e);
      @(negedge clk);
      if (junk) begin
         b = 8'($urandom);
         q = 8'($urandom);
      end
      idle_cyc = idle_cyc + 18 + $countones(qq);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            if (d_end) begin
               if (sb_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_pulse: got d_end=1 at cycle %0d, expected no pulse", cyc);
               end else begin
                  e = sb_q.pop_front();
                  check("product", {16'd0, result}, {16'd0, e.prod});
                  check("done_cycle", cyc, e.done_cyc);
                  $display("op b=0x%02h q=0x%02h result=0x%04h cycle=%0d", e.b, e.q, result, cyc);
               end
            end else if (sb_q.size() > 0 && cyc > sb_q[0].done_cyc) begin
               e = sb_q.pop_front();
               n_checks++;
               n_fail++;
               $display("FAIL missing_pulse: got no d_end by cycle %0d, expected pulse at cycle %0d (b=0x%02h q=0x%02h)",
                        cyc, e.done_cyc, e.b, e.q);
            end
         end
      end
   end

   initial begin : stimulus
      int shift4;
      logic [7:0] rb, rq;
      #2 rst = 1'b0;
      #1;
      check("reset_result", {16'd0, result}, 32'd0);
      check("reset_d_end", {31'd0, d_end}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      idle_cyc = 0;

      run_op(8'h0F, 8'h0F, 1'b0);
      run_op(8'hFF, 8'hFF, 1'b0);
      run_op(8'hAB, 8'h00, 1'b0);
      run_op(8'h00, 8'h80, 1'b1);
      run_op(8'h05, 8'h03, 1'b1);

      // Abort during the 4th SHIFT of an all-ones operation (A is nonzero there).
      run_op(8'hFF, 8'hFF, 1'b0);
      shift4 = 1;
      for (int j = 0; j < 4; j++) shift4 = shift4 + 2 + 1;
      shift4 = idle_cyc - (18 + 8) + shift4 - 1;
      while (cyc < shift4) @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort_result", {16'd0, result}, 32'd0);
      check("abort_d_end", {31'd0, d_end}, 32'd0);
      sb_q.delete();
      repeat (2) @(negedge clk);
      check("held_reset_result", {16'd0, result}, 32'd0);
      rst = 1'b1;
      idle_cyc = 0;
      run_op(8'hC3, 8'h5A, 1'b1);

      for (int i = 0; i < 1000; i++) begin
         rb = 8'($urandom);
         rq = 8'($urandom);
         if (i % 50 == 0) rq = 8'h00;
         if (i % 50 == 1) rq = 8'hFF;
         run_op(rb, rq, 1'b1);
      end

      for (int w = 0; w < 100 && sb_q.size() > 0; w++) @(negedge clk);
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d outstanding operations, expected 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
